// File: rtl/fu_issue_arbiter_if.sv
// Issue-side handshake between the issue ports and the FU issue arbiter.
// Each port raises req with its FU code; gnt is the same-cycle issue_ack.
interface fu_issue_arbiter_if #(
    parameter int NR_ISSUE_PORTS = 2
);
    logic [NR_ISSUE_PORTS-1:0]   req;
    logic [NR_ISSUE_PORTS*3-1:0] req_fu;
    logic [NR_ISSUE_PORTS-1:0]   gnt;

    modport master (output req, output req_fu, input gnt);
    modport slave  (input req, input req_fu, output gnt);
endinterface

// File: rtl/fu_issue_arbiter.sv
// In-order issue arbiter: grants ports oldest-first with one grant per FU type,
// and registers per-FU valids, source-port selects and branch/CSR pending flags.
module fu_issue_arbiter #(
    parameter int NR_ISSUE_PORTS = 2,
    parameter int CNT_WIDTH      = 16,
    localparam int PW            = (NR_ISSUE_PORTS > 1) ? $clog2(NR_ISSUE_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    fu_issue_arbiter_if.slave    issue,
    input  logic                 flu_ready_i,
    input  logic                 lsu_ready_i,
    input  logic                 fpu_ready_i,
    input  logic                 resolve_branch_i,
    input  logic                 csr_commit_i,
    output logic                 alu_valid_o,
    output logic                 branch_valid_o,
    output logic                 csr_valid_o,
    output logic                 mult_valid_o,
    output logic                 lsu_valid_o,
    output logic                 fpu_valid_o,
    output logic [6*PW-1:0]      fu_port_o,
    output logic                 branch_pending_o,
    output logic [CNT_WIDTH-1:0] struct_stall_cnt_o
);
    localparam logic [2:0] FU_NONE = 3'd0;
    localparam logic [2:0] FU_ALU  = 3'd1;
    localparam logic [2:0] FU_CTRL = 3'd2;
    localparam logic [2:0] FU_CSR  = 3'd3;
    localparam logic [2:0] FU_MULT = 3'd4;
    localparam logic [2:0] FU_LSU  = 3'd5;
    localparam logic [2:0] FU_FPU  = 3'd6;

    localparam int B_CTRL = 1;
    localparam int B_CSR  = 2;

    logic [NR_ISSUE_PORTS-1:0] gnt;
    logic [5:0]                fu_taken;   // bit k: FU code k+1 granted this cycle
    logic [5:0][PW-1:0]        fu_port_d;
    logic [5:0][PW-1:0]        fu_port_q;
    logic [5:0]                valid_q;
    logic                      branch_pending_q;
    logic                      csr_pending_q;
    logic [CNT_WIDTH-1:0]      stall_cnt_q;
    logic [2:0]                code;
    logic [5:0]                onehot;
    logic                      avail;
    logic                      chain;

    // A single running 'chain' bit carries in-order blocking: once a port
    // misses, every younger port is denied regardless of its own FU.
    always_comb begin
        gnt       = '0;
        fu_taken  = '0;
        fu_port_d = fu_port_q;
        code      = FU_NONE;
        onehot    = '0;
        avail     = 1'b0;
        chain     = !flush_i;
        for (int p = 0; p < NR_ISSUE_PORTS; p++) begin
            code   = issue.req_fu[p*3 +: 3];
            onehot = (code >= FU_ALU && code <= FU_FPU) ? 6'(6'b1 << (code - 3'd1)) : 6'b0;
            case (code)
                FU_NONE:          avail = 1'b1;
                FU_ALU, FU_MULT:  avail = flu_ready_i;
                FU_CTRL:          avail = flu_ready_i && !branch_pending_q && !fu_taken[B_CSR];
                FU_CSR:           avail = flu_ready_i && !csr_pending_q && !fu_taken[B_CTRL];
                FU_LSU:           avail = lsu_ready_i;
                FU_FPU:           avail = fpu_ready_i;
                default:          avail = 1'b0;
            endcase
            chain  = chain && issue.req[p] && avail && ((onehot & fu_taken) == 6'b0);
            gnt[p] = chain;
            if (chain) begin
                fu_taken = fu_taken | onehot;
                for (int k = 0; k < 6; k++) begin
                    if (onehot[k]) fu_port_d[k] = PW'(p);
                end
            end
        end
    end

    assign issue.gnt = gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q          <= '0;
            fu_port_q        <= '0;
            branch_pending_q <= 1'b0;
            csr_pending_q    <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            valid_q   <= flush_i ? 6'b0 : fu_taken;
            fu_port_q <= fu_port_d;
            if (flush_i)               branch_pending_q <= 1'b0;
            else if (fu_taken[B_CTRL]) branch_pending_q <= 1'b1;
            else if (resolve_branch_i) branch_pending_q <= 1'b0;
            if (flush_i)               csr_pending_q <= 1'b0;
            else if (fu_taken[B_CSR])  csr_pending_q <= 1'b1;
            else if (csr_commit_i)     csr_pending_q <= 1'b0;
            if (issue.req[0] && !gnt[0] && !flush_i && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign alu_valid_o        = valid_q[0];
    assign branch_valid_o     = valid_q[1];
    assign csr_valid_o        = valid_q[2];
    assign mult_valid_o       = valid_q[3];
    assign lsu_valid_o        = valid_q[4];
    assign fpu_valid_o        = valid_q[5];
    assign fu_port_o          = fu_port_q;
    assign branch_pending_o   = branch_pending_q;
    assign struct_stall_cnt_o = stall_cnt_q;

    // Code 7 is reserved; an upstream decoder must never request it.
    for (genvar p = 0; p < NR_ISSUE_PORTS; p++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(issue.req[p] && issue.req_fu[p*3 +: 3] == 3'd7));
    end
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter: vector table plus hand-written
// sequences for reset, branch/CSR single-outstanding, flush and saturation.
module tb_fu_issue_arbiter;
    localparam int N      = 2;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;
    localparam logic [2:0] FN = 3'd0, FA = 3'd1, FC = 3'd2, FS = 3'd3,
                           FM = 3'd4, FL = 3'd5, FF = 3'd6;

    typedef struct {
        logic       flush;
        logic [1:0] req;
        logic [2:0] fu0;
        logic [2:0] fu1;
        logic       flu;
        logic       lsu;
        logic       fpu;
        logic [1:0] gnt;
        logic [5:0] valid;   // {FPU,LSU,MULT,CSR,CTRL,ALU}
        logic [5:0] port;    // granted port per FU, same order
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic flu_ready_i = 1'b0, lsu_ready_i = 1'b0, fpu_ready_i = 1'b0;
    logic resolve_branch_i = 1'b0, csr_commit_i = 1'b0;
    logic alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, lsu_valid_o, fpu_valid_o;
    logic [5:0]    fu_port_o;
    logic          branch_pending_o;
    logic [CW-1:0] struct_stall_cnt_o;
    logic [5:0]    valids;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [5:0] port_m = '0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_v;
    vec_t vecs[15];

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    fu_issue_arbiter_if #(.NR_ISSUE_PORTS(N)) issue ();

    fu_issue_arbiter #(.NR_ISSUE_PORTS(N), .CNT_WIDTH(CW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .issue              (issue),
        .flu_ready_i        (flu_ready_i),
        .lsu_ready_i        (lsu_ready_i),
        .fpu_ready_i        (fpu_ready_i),
        .resolve_branch_i   (resolve_branch_i),
        .csr_commit_i       (csr_commit_i),
        .alu_valid_o        (alu_valid_o),
        .branch_valid_o     (branch_valid_o),
        .csr_valid_o        (csr_valid_o),
        .mult_valid_o       (mult_valid_o),
        .lsu_valid_o        (lsu_valid_o),
        .fpu_valid_o        (fpu_valid_o),
        .fu_port_o          (fu_port_o),
        .branch_pending_o   (branch_pending_o),
        .struct_stall_cnt_o (struct_stall_cnt_o)
    );

    assign valids = {fpu_valid_o, lsu_valid_o, mult_valid_o, csr_valid_o, branch_valid_o, alu_valid_o};

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] req, input logic [2:0] f0, input logic [2:0] f1,
                         input logic flu, input logic lsu, input logic fpu,
                         input logic rb, input logic cc);
        @(negedge clk);
        flush_i          = fl;
        issue.req        = req;
        issue.req_fu     = {f1, f0};
        flu_ready_i      = flu;
        lsu_ready_i      = lsu;
        fpu_ready_i      = fpu;
        resolve_branch_i = rb;
        csr_commit_i     = cc;
    endtask

    // Checks the combinational grant, advances one edge, checks the stall counter.
    task automatic step(input string name, input logic [1:0] exp_gnt);
        #1;
        check({name, " gnt"}, 32'(issue.gnt), 32'(exp_gnt));
        if (issue.req[0] && !exp_gnt[0] && !flush_i && exp_cnt < CNTMAX) exp_cnt++;
        @(posedge clk);
        #1;
        check({name, " stall_cnt"}, 32'(struct_stall_cnt_o), 32'(exp_cnt));
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        vecs[0]  = '{1'b0, 2'b00, FN, FN, 1'b1, 1'b1, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[1]  = '{1'b0, 2'b11, FA, FL, 1'b1, 1'b1, 1'b1, 2'b11, 6'b010001, 6'b010000};
        vecs[2]  = '{1'b0, 2'b11, FM, FM, 1'b1, 1'b1, 1'b1, 2'b01, 6'b001000, 6'b000000};
        vecs[3]  = '{1'b0, 2'b11, FL, FA, 1'b1, 1'b0, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[4]  = '{1'b0, 2'b11, FL, FA, 1'b1, 1'b0, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[5]  = '{1'b0, 2'b11, FL, FA, 1'b1, 1'b1, 1'b1, 2'b11, 6'b010001, 6'b000001};
        vecs[6]  = '{1'b0, 2'b11, FN, FN, 1'b1, 1'b1, 1'b1, 2'b11, 6'b000000, 6'b000000};
        vecs[7]  = '{1'b0, 2'b11, FN, FF, 1'b1, 1'b1, 1'b1, 2'b11, 6'b100000, 6'b100000};
        vecs[8]  = '{1'b0, 2'b10, FN, FA, 1'b1, 1'b1, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[9]  = '{1'b0, 2'b11, FA, FM, 1'b0, 1'b1, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[10] = '{1'b0, 2'b01, FF, FN, 1'b1, 1'b1, 1'b0, 2'b00, 6'b000000, 6'b000000};
        vecs[11] = '{1'b0, 2'b11, FF, FF, 1'b1, 1'b1, 1'b1, 2'b01, 6'b100000, 6'b000000};
        vecs[12] = '{1'b1, 2'b11, FA, FL, 1'b1, 1'b1, 1'b1, 2'b00, 6'b000000, 6'b000000};
        vecs[13] = '{1'b0, 2'b11, FA, FF, 1'b1, 1'b1, 1'b0, 2'b01, 6'b000001, 6'b000000};
        vecs[14] = '{1'b0, 2'b11, FM, FA, 1'b1, 1'b1, 1'b1, 2'b11, 6'b001001, 6'b000001};

        issue.req    = '0;
        issue.req_fu = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("reset valids", 32'(valids), 32'h0);
        check("reset ports", 32'(fu_port_o), 32'h0);
        check("reset pending", 32'(branch_pending_o), 32'h0);
        check("reset stall_cnt", 32'(struct_stall_cnt_o), 32'h0);

        // Asynchronous reset in the middle of activity.
        drive(1'b0, 2'b11, FC, FL, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("pre_reset", 2'b11);
        check("pre_reset pending", 32'(branch_pending_o), 32'h1);
        check("pre_reset lsu_valid", 32'(lsu_valid_o), 32'h1);
        #2;
        rst_ni    = 1'b0;
        issue.req = '0;
        #1;
        check("async valids", 32'(valids), 32'h0);
        check("async pending", 32'(branch_pending_o), 32'h0);
        check("async ports", 32'(fu_port_o), 32'h0);
        @(negedge clk);
        rst_ni  = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].flush, vecs[i].req, vecs[i].fu0, vecs[i].fu1,
                  vecs[i].flu, vecs[i].lsu, vecs[i].fpu, 1'b0, 1'b0);
            exp_q.push_back(vecs[i].valid);
            step($sformatf("vec%0d", i), vecs[i].gnt);
            exp_v = exp_q.pop_front();
            for (int k = 0; k < 6; k++) if (exp_v[k]) port_m[k] = vecs[i].port[k];
            check($sformatf("vec%0d valids", i), 32'(valids), 32'(exp_v));
            check($sformatf("vec%0d ports", i), 32'(fu_port_o), 32'(port_m));
        end

        // Branch single-outstanding.
        drive(1'b0, 2'b01, FC, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("br_issue", 2'b01);
        check("br_issue valid", 32'(branch_valid_o), 32'h1);
        check("br_issue pending", 32'(branch_pending_o), 32'h1);
        check("br_issue port", 32'(fu_port_o[1]), 32'h0);
        drive(1'b0, 2'b01, FC, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("br_blocked", 2'b00);
        check("br_blocked valid", 32'(branch_valid_o), 32'h0);
        check("br_blocked pending", 32'(branch_pending_o), 32'h1);
        drive(1'b0, 2'b01, FC, FN, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("br_resolve", 2'b00);
        check("br_resolve pending", 32'(branch_pending_o), 32'h0);
        drive(1'b0, 2'b01, FC, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("br_regrant", 2'b01);
        check("br_regrant valid", 32'(branch_valid_o), 32'h1);
        drive(1'b0, 2'b00, FN, FN, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("br_idle_resolve", 2'b00);
        check("br_idle_resolve pending", 32'(branch_pending_o), 32'h0);

        // CTRL and CSR exclude each other within one cycle.
        drive(1'b0, 2'b11, FC, FS, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ctrl_csr", 2'b01);
        check("ctrl_csr valids", 32'(valids), 32'h02);
        drive(1'b0, 2'b01, FS, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("csr_issue", 2'b01);
        check("csr_issue valid", 32'(csr_valid_o), 32'h1);

        // Flush with both pending flags set.
        drive(1'b1, 2'b11, FA, FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("flush", 2'b00);
        check("flush valids", 32'(valids), 32'h0);
        check("flush pending", 32'(branch_pending_o), 32'h0);
        drive(1'b0, 2'b01, FS, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("csr_after_flush", 2'b01);
        drive(1'b0, 2'b01, FS, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("csr_blocked", 2'b00);
        check("csr_blocked valid", 32'(csr_valid_o), 32'h0);
        drive(1'b0, 2'b00, FN, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("csr_commit", 2'b00);
        drive(1'b0, 2'b01, FS, FN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("csr_regrant", 2'b01);
        check("csr_regrant valid", 32'(csr_valid_o), 32'h1);

        // Stall counter saturation.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 2'b01, FL, FN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            step($sformatf("sat%0d", i), 2'b00);
        end
        check("saturated", 32'(struct_stall_cnt_o), 32'(CNTMAX));

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Sits between the per-port issue_read_operands instances and the shared functional units (FLU group: ALU/branch/CSR/mult; LSU; FPU).
- Each cycle it decides which issue ports may issue, enforcing three rules:
  - strict in-order issue: port 0 is the oldest.
  - at most one grant per FU type per cycle.
  - FU readiness, plus single-outstanding rules for branch and CSR.
- It produces registered per-FU valids and a per-FU source-port select, which replace the plain OR of per-port valids.

Parameters:
NR_ISSUE_PORTS, 2, number of issue ports (1..4); port 0 always holds the oldest instruction.
CNT_WIDTH, 16, width of the structural-stall counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  kill all issue this cycle and clear pending state
req_i  in  NR_ISSUE_PORTS  port p holds a decoded, operand-ready instruction
req_fu_i  in  NR_ISSUE_PORTS*3  requested FU per port: 0 NONE, 1 ALU, 2 CTRL, 3 CSR, 4 MULT, 5 LSU, 6 FPU, 7 reserved
gnt_o  out  NR_ISSUE_PORTS  combinational issue grant (issue_ack) per port
flu_ready_i  in  1  FLU group can accept
lsu_ready_i  in  1  LSU can accept
fpu_ready_i  in  1  FPU can accept
resolve_branch_i  in  1  outstanding branch resolved in EX
csr_commit_i  in  1  outstanding CSR instruction committed
alu_valid_o  out  1  registered
branch_valid_o  out  1  registered
csr_valid_o  out  1  registered
mult_valid_o  out  1  registered
lsu_valid_o  out  1  registered
fpu_valid_o  out  1  registered
fu_port_o  out  6*max(1,$clog2(NR_ISSUE_PORTS))  registered source port per FU; order ALU, CTRL, CSR, MULT, LSU, FPU
branch_pending_o  out  1  an issued branch is unresolved
struct_stall_cnt_o  out  CNT_WIDTH  saturating count of port-0 structural stalls

Behaviour:
- Reset (asynchronous, rst_ni low):
  - all *_valid_o, fu_port_o, branch_pending_o and struct_stall_cnt_o are 0.
  - gnt_o is combinational and is 0 while flush_i=1.
- Grant evaluation runs in port order p=0..N-1. gnt[p]=1 iff all of the following hold:
  - req_i[p]=1 and flush_i=0.
  - p==0 or gnt[p-1]=1 (in-order; a blocked port blocks all younger ports).
  - the requested FU is available.
  - that FU type has not already been granted to a lower port this cycle. NONE is exempt from this rule.
- FU availability:
  - NONE: always available.
  - ALU and MULT: flu_ready_i.
  - CTRL: flu_ready_i, branch_pending_q=0, and no CSR granted to a lower port this cycle.
  - CSR: flu_ready_i, csr_pending_q=0, and no CTRL granted to a lower port this cycle.
  - LSU: lsu_ready_i.
  - FPU: fpu_ready_i.
  - Code 7: never available. An assertion fires if req_i[p]=1 with code 7.
- Registered outputs (next edge after grant):
  - *_valid_o[fu] <= 1 iff some port was granted that FU. Latency is exactly 1 cycle, aligned with the registered fu_data of issue_read_operands.
  - fu_port_o[fu] <= index of the granted port; it holds its value when the FU is not granted.
  - NONE grants raise no valid.
  - flush_i forces all valids to 0 on the next edge.
- branch_pending_q:
  - set on a CTRL grant.
  - cleared on resolve_branch_i.
  - set and clear in the same cycle cannot occur, because a CTRL grant requires pending=0. A resolve while pending=0 is ignored.
  - flush_i clears it.
  - branch_pending_o = branch_pending_q.
- csr_pending_q:
  - set on a CSR grant.
  - cleared on csr_commit_i or flush_i.
  - A CSR grant and csr_commit_i in the same cycle cannot occur, because a CSR grant requires pending=0.
- struct_stall_cnt:
  - increments when req_i[0]=1, gnt[0]=0 and flush_i=0.
  - saturates at all-ones.
  - not cleared by flush_i.
- Combinational path: gnt_o depends on req_i, req_fu_i, ready inputs, flush_i and pending flags only. There is no path from *_valid_o back to gnt_o.
- With NR_ISSUE_PORTS=1 the block degenerates to readiness gating plus registered valids.

Test Plan:
- Reset then idle:
  - Stimulus: rst_ni low mid-operation with branch_pending=1 and lsu_valid_o=1.
  - Response: all outputs 0 immediately (asynchronous); after release, req_i=0 gives gnt_o=00.
- Dual issue, different FUs:
  - Stimulus: req_i=11, fu={ALU, LSU}, all ready.
  - Response: gnt_o=11. Next cycle alu_valid_o=1 with fu_port ALU=0, and lsu_valid_o=1 with fu_port LSU=1.
- Same-FU conflict:
  - Stimulus: req_i=11, fu={MULT, MULT}.
  - Response: gnt_o=01, mult_valid_o=1 with port 0 next cycle. Next cycle, with port 1 shifted into port 0, gnt_o[0]=1.
- In-order block:
  - Stimulus: fu={LSU, ALU}, lsu_ready_i=0.
  - Response: gnt_o=00 and struct_stall_cnt increments by 1 per cycle; after lsu_ready_i=1, gnt_o=11.
- Branch single-outstanding:
  - Stimulus: CTRL granted on port 0; next cycle a new CTRL request arrives.
  - Response: gnt_o[0]=0 while branch_pending_o=1. resolve_branch_i pulse clears pending; the following cycle the CTRL request is granted.
- Flush priority:
  - Stimulus: flush_i=1 with req_i=11, fu={ALU, FPU}, branch_pending=1, csr_pending=1.
  - Response: gnt_o=00 that cycle, all valids 0 next cycle, both pending flags 0, stall counter unchanged.
